// File: rtl/seq_shift_add_multiplier.sv
// Iterative radix-2 shift-add multiplier with signed/unsigned and multiply-accumulate modes.
// One partial product per clock: IDLE -> WIDTH RUN cycles -> one DONE cycle.
module seq_shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic                 acc_mode,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   mul
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [PW-1:0]    sum_q, sum_d;
   logic             neg_q, neg_d;
   logic             acc_q, acc_d;
   logic [PW-1:0]    mul_q, mul_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [PW-1:0]    addend, sum_next, product;

   // Signed operands become magnitudes at latch time; the most negative value maps to 2^(WIDTH-1).
   always_comb begin
      a_mag = multiplicand;
      b_mag = multiplier;
      if (signed_mode && multiplicand[WIDTH-1]) a_mag = (~multiplicand) + WIDTH'(1);
      if (signed_mode && multiplier[WIDTH-1])   b_mag = (~multiplier) + WIDTH'(1);
   end

   always_comb begin
      addend   = mplier_q[0] ? mcand_q : '0;
      sum_next = sum_q + addend;
      product  = neg_q ? ((~sum_next) + PW'(1)) : sum_next;
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      sum_d    = sum_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      mul_d    = mul_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               count_d  = '0;
               mcand_d  = PW'(a_mag);
               mplier_d = b_mag;
               sum_d    = '0;
               neg_d    = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
               acc_d    = acc_mode;
            end
         end
         RUN: begin
            sum_d    = sum_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            // Last partial product: the result register updates on the same edge that raises done.
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               count_d = '0;
               mul_d   = acc_q ? (mul_q + product) : product;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         sum_q    <= '0;
         neg_q    <= 1'b0;
         acc_q    <= 1'b0;
         mul_q    <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         sum_q    <= sum_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         mul_q    <= mul_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign mul  = mul_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: directed vectors with literal results plus a
// cycle-level arithmetic model checked against busy/done/mul on every cycle.
module tb_seq_shift_add_multiplier;

   parameter int W = 8;
   localparam int NRAND = 1000;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           signed_mode = 1'b0;
   logic           acc_mode = 1'b0;
   logic [W-1:0]   multiplicand = '0;
   logic [W-1:0]   multiplier = '0;
   logic           busy, done;
   logic [2*W-1:0] mul;

   int total = 0;
   int bad = 0;

   seq_shift_add_multiplier #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .signed_mode  (signed_mode),
      .acc_mode     (acc_mode),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .mul          (mul)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Plain integer arithmetic on the operand values, wrapped to 2*W bits.
   function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic sm, input logic am,
                                                input logic [2*W-1:0] prev);
      longint av, bv, p;
      av = longint'(a);
      bv = longint'(b);
      if (sm && a[W-1]) av = av - (longint'(1) << W);
      if (sm && b[W-1]) bv = bv - (longint'(1) << W);
      p = av * bv;
      if (am) p = p + longint'(prev);
      return p[2*W-1:0];
   endfunction

   // Model: an accepted op keeps the unit busy for W+1 cycles, the last of which is the done cycle.
   int             m_left = 0;
   logic [2*W-1:0] m_mul = '0;
   logic [2*W-1:0] m_pend = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0;
         m_mul  = '0;
      end else if (m_left == 0) begin
         if (start) begin
            m_pend = model_mul(multiplicand, multiplier, signed_mode, acc_mode, m_mul);
            m_left = W + 1;
         end
      end else begin
         m_left = m_left - 1;
         if (m_left == 1) m_mul = m_pend;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check_output("busy", 64'(busy), 64'(m_left != 0));
         check_output("done", 64'(done), 64'(m_left == 1));
         check_output("mul",  64'(mul),  64'(m_mul));
      end
   end

   task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sm, input logic am);
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      signed_mode  = sm;
      acc_mode     = am;
      start        = 1'b1;
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         input logic am, input logic [2*W-1:0] exp, input string nm);
      int edges;
      apply_stimulus(a, b, sm, am);
      @(posedge clk);
      #1 start = 1'b0;
      edges = 1;
      while (!done && edges < 4 * W + 8) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check_output({nm, "_latency"}, 64'(edges), 64'(W + 1));
      check_output({nm, "_mul"}, 64'(mul), 64'(exp));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cyc, last, dones, guard;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("reset_busy", 64'(busy), 64'd0);
      check_output("reset_done", 64'(done), 64'd0);
      check_output("reset_mul",  64'(mul),  64'd0);
      rst = 1'b0;

      run_op(8'd200, 8'd255, 1'b0, 1'b0, 16'hC738, "u200x255");
      run_op(8'hFF,  8'hFF,  1'b0, 1'b0, 16'hFE01, "u255x255");
      run_op(8'd0,   8'd77,  1'b0, 1'b0, 16'h0000, "u0x77");
      run_op(8'h80,  8'h80,  1'b1, 1'b0, 16'h4000, "s_m128xm128");
      run_op(8'hFF,  8'h7F,  1'b1, 1'b0, 16'hFF81, "s_m1x127");
      run_op(8'h7F,  8'h80,  1'b1, 1'b0, 16'hC080, "s_127xm128");
      run_op(8'hFF,  8'hFF,  1'b0, 1'b0, 16'hFE01, "u_ffxff");
      run_op(8'd3,   8'd4,   1'b0, 1'b0, 16'h000C, "acc_3x4");
      run_op(8'd5,   8'd6,   1'b0, 1'b1, 16'h002A, "acc_5x6");
      run_op(8'hFF,  8'h01,  1'b1, 1'b0, 16'hFFFF, "seed_ffff");
      run_op(8'hFF,  8'hFF,  1'b0, 1'b1, 16'hFE00, "acc_wrap");

      // Starts issued in RUN and in DONE must not disturb the op in flight.
      apply_stimulus(8'd10, 8'd20, 1'b0, 1'b0);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      multiplicand = 8'd99; multiplier = 8'd99; acc_mode = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      guard = 0;
      while (!done && guard < 4 * W) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check_output("ignore_run_mul", 64'(mul), 64'd200);
      multiplicand = 8'd7; multiplier = 8'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check_output("ignore_done_busy", 64'(busy), 64'd0);
      check_output("ignore_done_mul", 64'(mul), 64'd200);

      // Asynchronous reset in the middle of RUN clears outputs before the next edge.
      apply_stimulus(8'd3, 8'd3, 1'b0, 1'b0);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_output("midrun_rst_busy", 64'(busy), 64'd0);
      check_output("midrun_rst_done", 64'(done), 64'd0);
      check_output("midrun_rst_mul",  64'(mul),  64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(8'd3, 8'd5, 1'b0, 1'b1, 16'h000F, "after_rst");

      // Start held high with operands changing every cycle; results come from the model.
      cyc = 0; last = 0; dones = 0;
      start = 1'b1;
      while (dones < NRAND && cyc < NRAND * (W + 2) + 100) begin
         @(negedge clk);
         multiplicand = W'($urandom % (1 << W));
         multiplier   = W'($urandom % (1 << W));
         signed_mode  = 1'($urandom_range(0, 1));
         acc_mode     = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         cyc++;
         if (done) begin
            if (dones > 0) check_output("rand_period", 64'(cyc - last), 64'(W + 2));
            last = cyc;
            dones++;
         end
      end
      check_output("rand_done_count", 64'(dones), 64'(NRAND));
      start = 1'b0;
      repeat (W + 4) @(posedge clk);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
